bnn_infer_sequencer: RTL
========================

Name: bnn_infer_sequencer

Overview:
Run-control wrapper for the sequential ROM-based BNN classifier core (features, clk, rst, prediction). Accepts one packed feature vector per valid/ready handshake and latches it for the core. Pulses the core's reset, waits the fixed hidden+class evaluation window, captures the class index and presents it on a valid/ready result port. Replaces the ad-hoc reset/wait sequencing in benches and lets a system stream samples through one core.

Parameters:
FEAT_CNT, 16, number of input features
FEAT_BITS, 4, bits per feature
HIDDEN_CNT, 40, hidden neurons; the core evaluates one per cycle
CLASS_CNT, 10, output classes; the core evaluates one per cycle
SETTLE_CYCLES, HIDDEN_CNT+CLASS_CNT, core evaluation cycles after its reset is released

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  feature vector offered
in_ready  out  1  sequencer can accept a vector
in_features  in  FEAT_BITS*FEAT_CNT  packed feature vector
out_valid  out  1  classification result available
out_ready  in  1  consumer takes the result
out_class  out  $clog2(CLASS_CNT)  predicted class
out_range_err  out  1  core returned an index >= CLASS_CNT; out_class is clamped
bnn_features  out  FEAT_BITS*FEAT_CNT  to core features; registered, stable for a whole run
bnn_rst  out  1  to core rst, active-high
bnn_prediction  in  $clog2(CLASS_CNT)  from core prediction

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, out_valid=0, out_class=0, out_range_err=0, bnn_features=0, in_ready=0.
- While rst=0: bnn_rst=1 (combinational from rst), so the core is held in reset.
- After reset releases: in_ready=1 from the first clock edge.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_features into bnn_features, go to LOAD.
- LOAD:
  - bnn_rst=1 for exactly this one cycle; in_ready=0.
  - Next state RUN, counter=0.
- RUN:
  - bnn_rst=0; counter increments each cycle.
  - At the edge where counter==SETTLE_CYCLES: capture bnn_prediction, go to DONE.
  - The RUN window is SETTLE_CYCLES+1 cycles, giving one margin cycle.
- Capture rule:
  - If bnn_prediction > CLASS_CNT-1: out_class=CLASS_CNT-1 and out_range_err=1.
  - Otherwise out_class=bnn_prediction and out_range_err=0.
- DONE:
  - out_valid=1; out_class and out_range_err are held stable until out_ready.
  - On out_valid&out_ready: out_valid goes to 0 at that edge and the next state is IDLE.
- Latency: out_valid rises exactly SETTLE_CYCLES+2 edges after the accepting edge (52 with defaults).
- Stability: bnn_features changes only at an accept edge and never during LOAD/RUN/DONE.
- Widths: counter is $clog2(SETTLE_CYCLES+1) bits and never wraps; it saturates at its terminal count and resets on LOAD.
- in_valid while not ready: ignored, no state change. in_features may change freely while in_ready=0.
- Reset mid-run (any state): immediate return to IDLE; any pending result is discarded, with no out_valid glitch.

Optional Feature:
Macro BNN_INFER_SEQUENCER_PREFETCH_EN.
- Enabled:
  - Adds a one-entry input buffer (pend_valid, pend_features).
  - in_ready = (state==IDLE) | ~pend_valid.
  - An accept in LOAD/RUN/DONE fills the buffer.
  - A DONE handshake with pend_valid=1 copies pend_features into bnn_features, clears pend_valid and goes directly to LOAD, skipping IDLE.
  - An accept on that same edge refills the buffer.
  - Reset clears pend_valid.
- Disabled: there is no buffer; in_ready=1 only in IDLE.

Test Plan:
- Reset hold: rst=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, bnn_rst=1 throughout; no accept.
- Single run: accept vector 0x0123456789ABCDEF, core model returns 7 -> bnn_rst high for exactly 1 cycle; bnn_features=0x0123456789ABCDEF; out_valid at accept+52; out_class=7, out_range_err=0.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_class held; in_ready=0 (PREFETCH off); release -> IDLE, next accept 1 cycle later.
- Clamp: core returns 12 -> out_class=9, out_range_err=1.
- Reset mid-RUN: rst=0 at counter=25 -> out_valid stays 0, state IDLE; the new vector after release runs the full 52 cycles.
- Prefetch (macro on): second vector offered during RUN -> accepted; after first result handshake, LOAD starts on the next cycle; second out_valid arrives 52 edges after that handshake.

Source files
------------

// File: rtl/bnn_infer_sequencer.sv
// Run-control wrapper for the sequential BNN classifier core: latches a feature vector,
// pulses the core reset, waits the evaluation window and returns the clamped class index.
// Optional build macro BNN_INFER_SEQUENCER_PREFETCH_EN adds a one-entry input buffer.
module bnn_infer_sequencer #(
    parameter int FEAT_CNT      = 16,
    parameter int FEAT_BITS     = 4,
    parameter int HIDDEN_CNT    = 40,
    parameter int CLASS_CNT     = 10,
    parameter int SETTLE_CYCLES = HIDDEN_CNT + CLASS_CNT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FEAT_BITS*FEAT_CNT-1:0] in_features,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(CLASS_CNT)-1:0]  out_class,
    output logic                          out_range_err,
    output logic [FEAT_BITS*FEAT_CNT-1:0] bnn_features,
    output logic                          bnn_rst,
    input  logic [$clog2(CLASS_CNT)-1:0]  bnn_prediction
);

    localparam int FEAT_W = FEAT_BITS * FEAT_CNT;
    localparam int CLS_W  = $clog2(CLASS_CNT);
    localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(SETTLE_CYCLES);
    localparam logic [CLS_W-1:0] CLS_MAX  = CLS_W'(CLASS_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [FEAT_W-1:0]  feat_r;
    logic [CLS_W-1:0]   out_class_r;
    logic               out_range_err_r;
    logic               out_valid_r;
    logic               in_ready_r;
    logic               accept_s;
    logic               busy_ready_s;

    // Out-of-range core indices saturate to the last class and raise the error flag
    function automatic logic [CLS_W:0] clamp_pred(input logic [CLS_W-1:0] pred);
        logic [CLS_W:0] res;
        if (pred > CLS_MAX) begin
            res = {1'b1, CLS_MAX};
        end else begin
            res = {1'b0, pred};
        end
        return res;
    endfunction

    assign accept_s = in_valid & in_ready_r;

`ifdef BNN_INFER_SEQUENCER_PREFETCH_EN
    logic               pend_valid_r;
    logic [FEAT_W-1:0]  pend_feat_r;
    logic               fill_s;
    logic               drain_s;

    assign fill_s       = accept_s & (state_r != ST_IDLE);
    assign drain_s      = (state_r == ST_DONE) & out_ready;
    assign busy_ready_s = ~(pend_valid_r | fill_s);
`else
    assign busy_ready_s = 1'b0;
`endif

    // Sequencing FSM: core reset pulse, settle counter, result capture and handshake registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            cnt_r           <= '0;
            feat_r          <= '0;
            out_class_r     <= '0;
            out_range_err_r <= 1'b0;
            out_valid_r     <= 1'b0;
            in_ready_r      <= 1'b0;
`ifdef BNN_INFER_SEQUENCER_PREFETCH_EN
            pend_valid_r    <= 1'b0;
            pend_feat_r     <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        feat_r     <= in_features;
                        state_r    <= ST_LOAD;
                        in_ready_r <= busy_ready_s;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    cnt_r      <= '0;
                    state_r    <= ST_RUN;
                    in_ready_r <= busy_ready_s;
                end
                ST_RUN: begin
                    in_ready_r <= busy_ready_s;
                    if (cnt_r == CNT_TERM) begin
                        {out_range_err_r, out_class_r} <= clamp_pred(bnn_prediction);
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
`ifdef BNN_INFER_SEQUENCER_PREFETCH_EN
                        // A buffered vector (or one arriving now) starts the next run without idling
                        if (pend_valid_r) begin
                            feat_r     <= pend_feat_r;
                            state_r    <= ST_LOAD;
                            in_ready_r <= ~fill_s;
                        end else if (fill_s) begin
                            feat_r     <= in_features;
                            state_r    <= ST_LOAD;
                            in_ready_r <= 1'b1;
                        end else begin
                            state_r    <= ST_IDLE;
                            in_ready_r <= 1'b1;
                        end
`else
                        state_r    <= ST_IDLE;
                        in_ready_r <= 1'b1;
`endif
                    end else begin
                        in_ready_r <= busy_ready_s;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= '0;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b0;
                end
            endcase
`ifdef BNN_INFER_SEQUENCER_PREFETCH_EN
            if (drain_s) begin
                pend_valid_r <= 1'b0;
            end else if (fill_s) begin
                pend_valid_r <= 1'b1;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
            if (fill_s) begin
                pend_feat_r <= in_features;
            end else begin
                pend_feat_r <= pend_feat_r;
            end
`endif
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign out_class     = out_class_r;
    assign out_range_err = out_range_err_r;
    assign bnn_features  = feat_r;
    // The core sits in reset during system reset and for the single LOAD cycle
    assign bnn_rst       = ~rst | (state_r == ST_LOAD);

endmodule
